// File: rtl/spi_tx_slave.sv
// SPI transmit-only slave: a CLK-domain word FIFO feeding a 32-bit LSB-first shifter
// clocked by synchronized SCLK/CS_n edges. Define SPI_TX_STATS_EN to add sent/underrun counters.
module spi_tx_slave #(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter logic [31:0] UNDERRUN_WORD = 32'hDEAD_BEEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   wr_data_i,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  input  logic                          sclk_i,
  input  logic                          cs_n_i,
  output logic                          miso_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          word_sent_o,
  output logic                          underrun_o,
  output logic                          abort_o
`ifdef SPI_TX_STATS_EN
  ,
  output logic [15:0]                   sent_cnt_o,
  output logic [15:0]                   underrun_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  // ---------------------------------------------------------------------------
  // Synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] sclk_sync_q;
  logic [1:0] cs_sync_q;
  logic       sclk_prev_q;
  logic       cs_prev_q;
  logic [1:0] flush_cnt_q;
  logic       armed_q;
  logic       sclk_fall;
  logic       cs_fall;
  logic       cs_rise;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      flush_cnt_q <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk_i};
      cs_sync_q   <= {cs_sync_q[0], cs_n_i};
      sclk_prev_q <= sclk_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
      if (flush_cnt_q != 2'd2) flush_cnt_q <= flush_cnt_q + 2'd1;
      // Arm only once CS_n has truly been sampled high, not just the reset value
      if (flush_cnt_q == 2'd2 && cs_sync_q[1]) armed_q <= 1'b1;
    end
  end

  assign sclk_fall = sclk_prev_q & ~sclk_sync_q[1];
  assign cs_fall   = cs_prev_q & ~cs_sync_q[1] & armed_q;
  assign cs_rise   = ~cs_prev_q & cs_sync_q[1];

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  state_e        state_q;

  assign fifo_empty = (level_q == '0);
  assign wr_ready_o = (level_q != LW'(FIFO_DEPTH));
  assign push       = wr_valid_i & wr_ready_o;
  assign pop        = (state_q == LOAD) & ~fifo_empty;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // NOTE: storage array has no reset; occupancy is tracked by the pointers and
  // level, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign fifo_level_o = level_q;

  // ---------------------------------------------------------------------------
  // Frame FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic [31:0] shreg_q;
  logic [5:0]  bit_cnt_q;
  logic        miso_q;
  logic        word_sent_q;
  logic        underrun_q;
  logic        abort_q;
  logic [31:0] load_word;

  assign load_word = fifo_empty ? UNDERRUN_WORD : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      miso_q      <= 1'b0;
      word_sent_q <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      word_sent_q <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) state_q <= LOAD;
        end
        LOAD: begin
          shreg_q    <= load_word;
          bit_cnt_q  <= '0;
          underrun_q <= fifo_empty;
          if (cs_rise) begin
            abort_q <= 1'b1;
            miso_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            miso_q  <= load_word[0];
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            abort_q <= 1'b1;
            miso_q  <= 1'b0;
            state_q <= IDLE;
          end else if (sclk_fall) begin
            shreg_q   <= {1'b0, shreg_q[31:1]};
            bit_cnt_q <= bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'd31) begin
              // Last bit stays on MISO until CS_n rises
              word_sent_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              miso_q <= shreg_q[1];
            end
          end
        end
        DONE: begin
          if (cs_rise) begin
            miso_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso_o      = miso_q;
  assign word_sent_o = word_sent_q;
  assign underrun_o  = underrun_q;
  assign abort_o     = abort_q;

`ifdef SPI_TX_STATS_EN
  logic [15:0] sent_cnt_q;
  logic [15:0] underrun_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_cnt_q     <= '0;
      underrun_cnt_q <= '0;
    end else begin
      if (word_sent_q && sent_cnt_q != 16'hFFFF)    sent_cnt_q     <= sent_cnt_q + 16'd1;
      if (underrun_q && underrun_cnt_q != 16'hFFFF) underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign sent_cnt_o     = sent_cnt_q;
  assign underrun_cnt_o = underrun_cnt_q;
`endif

endmodule

// File: doc/spi_tx_slave.md
SPI_TX_SLAVE -- requirements
Module: spi_tx_slave

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: transmit FIFO depth in 32-bit words; power of two, 2..256.
REQ-002 Parameter UNDERRUN_WORD, default 32'hDEAD_BEEF: word shifted out when a frame starts with the FIFO empty.
REQ-003 CLK  in  1  system clock; all logic on rising edge; CLK period SHALL be at most SCLK period / 8.
REQ-004 RESET_n  in  1  asynchronous, active-low reset.
REQ-005 WR_DATA  in  32  word to queue for transmission.
REQ-006 WR_VALID  in  1  WR_DATA valid.
REQ-007 WR_READY  out  1  FIFO not full; a word is accepted on a CLK edge where WR_VALID && WR_READY.
REQ-008 SCLK  in  1  SPI clock from master, asynchronous to CLK, idle low.
REQ-009 CS_n  in  1  SPI chip select from master, asynchronous, active low.
REQ-010 MISO  out  1  serial data to master.
REQ-011 FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  words currently queued.
REQ-012 WORD_SENT  out  1  one-CLK pulse when the 32nd bit has been shifted.
REQ-013 UNDERRUN  out  1  one-CLK pulse when UNDERRUN_WORD is loaded.
REQ-014 ABORT  out  1  one-CLK pulse when CS_n rises with fewer than 32 bits shifted.

Function
REQ-015 SCLK and CS_n SHALL each pass through a 2-flop synchronizer; edges are detected on the synchronized copies.
REQ-016 Frame format: 32 bits, LSB first; MISO changes only after detected SCLK falling edge; master samples on SCLK rising edge.
REQ-017 FSM states IDLE, LOAD, SHIFT, DONE.
REQ-018 IDLE -> LOAD on synchronized CS_n falling edge.
REQ-019 LOAD (one CLK): pop FIFO head into 32-bit shift register, or load UNDERRUN_WORD and pulse UNDERRUN if empty; bit counter := 0; -> SHIFT.
REQ-020 MISO = shift register bit 0, valid within 4 CLK of CS_n falling, i.e. before the first SCLK rising edge.
REQ-021 SHIFT: each synchronized SCLK falling edge shifts right by one and increments the counter; on count 32 pulse WORD_SENT and -> DONE.
REQ-022 DONE: further SCLK edges ignored, MISO held at last value; CS_n rising -> IDLE.
REQ-023 CS_n rising in LOAD or SHIFT: pulse ABORT, -> IDLE; popped word is discarded, not re-queued.
REQ-024 One frame consumes exactly one FIFO word; a new CS_n falling edge is required for the next word.
REQ-025 In IDLE, MISO = 0.
REQ-026 Simultaneous write and pop in the same CLK: both take effect, FIFO_LEVEL unchanged; write and pop on empty FIFO: UNDERRUN_WORD is sent, written word is queued.
REQ-027 WR_READY = (FIFO_LEVEL < FIFO_DEPTH) when no pop occurs in that cycle; writes while full are ignored; read/write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-028 Reset values: FIFO empty, FIFO_LEVEL = 0, WR_READY = 1, MISO = 0, WORD_SENT = UNDERRUN = ABORT = 0, FSM = IDLE, synchronizers = SCLK 0 / CS_n 1.
REQ-029 If CS_n is low when reset deasserts, the block SHALL ignore that frame and arm only after CS_n has been seen high.
REQ-030 Reset asserted mid-frame SHALL drop the frame with no ABORT pulse.

Configuration
REQ-031 Macro SPI_TX_STATS_EN defined: adds outputs SENT_CNT [15:0] and UNDERRUN_CNT [15:0], saturating at 16'hFFFF, incremented with WORD_SENT / UNDERRUN, reset to 0.
REQ-032 Macro SPI_TX_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

Verification
REQ-033 Write 32'h1234_5678, master reads one frame (SCLK 1 us, CLK 10 ns) -> master receives 32'h1234_5678, one WORD_SENT pulse, FIFO_LEVEL 1 -> 0.
REQ-034 Frame with empty FIFO -> master receives 32'hDEAD_BEEF, one UNDERRUN pulse.
REQ-035 Write 16 words with WR_VALID held -> WR_READY low after 16th, 17th ignored; 16 frames return words in order, including across pointer wrap.
REQ-036 CS_n raised after 10 SCLK cycles -> one ABORT pulse, no WORD_SENT; next frame returns the following queued word.
REQ-037 RESET_n pulsed low mid-frame, CS_n kept low -> no MISO activity until CS_n high then low; next frame returns UNDERRUN_WORD.
REQ-038 With SPI_TX_STATS_EN: 3 good frames + 2 underrun frames -> SENT_CNT = 5, UNDERRUN_CNT = 2.
